// File: rtl/mem_error_reporter.sv
// Snapshots the first non-zero memory error vector and serialises each set bit
// as a (memory, lane) report over valid/ready, then raises a level irq.
module mem_error_reporter #(
  parameter int arraySize = 4,
  parameter int CNT_W     = 8,
  localparam int VEC_W    = 6 * arraySize,
  localparam int LANE_W   = (arraySize > 1) ? $clog2(arraySize) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VEC_W-1:0]  error,
  input  logic              report_ready,
  input  logic              irq_clear,
  output logic              report_valid,
  output logic [2:0]        report_mem,
  output logic [LANE_W-1:0] report_lane,
  output logic              report_last,
  output logic              irq,
  output logic [CNT_W-1:0]  error_count,
  output logic              busy
);

  // state    | meaning
  // IDLE     | waiting for a non-zero error vector
  // SCAN     | encode lowest pending bit into the report payload
  // SEND     | report presented, waiting for handshake
  // DONE     | all reports delivered, irq raised
  // WAIT_CLR | irq acknowledged, waiting for error vector to drop to zero
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    SEND     = 3'd2,
    DONE     = 3'd3,
    WAIT_CLR = 3'd4
  } state_t;

  localparam int IDX_W = (VEC_W > 1) ? $clog2(VEC_W) : 1;

  state_t            state;
  state_t            next_state;
  logic [VEC_W-1:0]  pending;
  logic [VEC_W-1:0]  pending_rest;
  logic [IDX_W-1:0]  low_idx;
  logic              handshake;

  // pending with its lowest set bit removed
  assign pending_rest = pending & (pending - VEC_W'(1));
  assign handshake    = (state == SEND) && report_ready;

  always_comb begin
    low_idx = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:     next_state = (error != '0) ? SCAN : IDLE;
      SCAN:     next_state = SEND;
      SEND: begin
        if (!report_ready)             next_state = SEND;
        else if (pending_rest == '0)   next_state = DONE;
        else                           next_state = SCAN;
      end
      DONE:     next_state = irq_clear ? WAIT_CLR : DONE;
      WAIT_CLR: next_state = (error == '0) ? IDLE : WAIT_CLR;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    report_valid = (state == SEND);
    irq          = (state == DONE);
    busy         = (state == SCAN) || (state == SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      report_mem  <= '0;
      report_lane <= '0;
      report_last <= 1'b0;
      error_count <= '0;
    end else begin
      if (state == IDLE && error != '0) pending <= error;
      if (state == SCAN) begin
        report_mem  <= 3'(low_idx / arraySize);
        report_lane <= LANE_W'(low_idx % arraySize);
        report_last <= (pending_rest == '0);
      end
      if (handshake) begin
        pending <= pending_rest;
        if (error_count != {CNT_W{1'b1}}) error_count <= error_count + CNT_W'(1);
      end
    end
  end

endmodule
